uart_tick_gen: RTL

UART_TICK_GEN -- requirements
Module: uart_tick_gen

---
 rtl/uart_tick_gen.sv | 107 ++++++++++
 1 files changed

// File: rtl/uart_tick_gen.sv
// Baud/sample tick generator: a wrapping counter with programmable period and start
// phase. It emits end-of-period and mid-period strobes, runs periodic or one-shot,
// and counts wraps.
module uart_tick_gen #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             mode,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] preset,
  input  logic             load,
  output logic             tick,
  output logic             mid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] tick_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_period_q;
  logic             r_mode_q;
  logic [CNT_W-1:0] r_tick_cnt;

  logic             w_last;
  logic             w_half;
  logic             w_active;
  logic             w_wrap;
  logic [WIDTH-1:0] w_idle_start;
  logic [WIDTH-1:0] w_load_start;

  // A preset outside the period would never reach the wrap point, so it falls back to 0.
  assign w_idle_start = (preset < period)     ? preset : '0;
  assign w_load_start = (preset < r_period_q) ? preset : '0;

  // r_period_q is never 0 in RUN, so the subtraction cannot underflow there.
  assign w_last   = (r_count == (r_period_q - WIDTH'(1)));
  assign w_half   = (r_count == (r_period_q >> 1));
  assign w_active = (r_state == S_RUN) && en && !load;
  assign w_wrap   = w_active && w_last;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_period_q <= '0;
      r_mode_q   <= 1'b0;
      r_tick_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_period_q <= period;
          r_mode_q   <= mode;
          r_tick_cnt <= '0;
          r_count    <= w_idle_start;
          if (en && (period != '0)) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (!en) begin
            r_state <= S_IDLE;
          end else if (load) begin
            r_count <= w_load_start;
          end else if (w_last) begin
            // A new period is adopted only at a wrap; a zero request keeps the old one.
            r_count    <= '0;
            r_tick_cnt <= r_tick_cnt + CNT_W'(1);
            if (period != '0) begin
              r_period_q <= period;
            end
            if (r_mode_q) begin
              r_state <= S_DONE;
            end
          end else begin
            r_count <= r_count + WIDTH'(1);
          end
        end
        S_DONE: begin
          r_count <= '0;
          if (!en) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign tick     = w_wrap;
  assign mid      = w_active && w_half;
  assign busy     = (r_state == S_RUN);
  assign done     = (r_state == S_DONE);
  assign tick_cnt = r_tick_cnt;

endmodule
